// File: rtl/sprite_jump_engine.sv
// Player vertical motion (parabolic jump, multi-jump, linear fall), run/duck frame
// selection and a two-stage sprite pixel pipe feeding an external synchronous ROM.
module sprite_jump_engine #(
   parameter int SPR_W       = 82,
   parameter int SPR_H       = 88,
   parameter int X0          = 80,
   parameter int GROUND_Y    = 402,
   parameter int JUMP_T      = 60,
   parameter int HDIV        = 6,
   parameter int MAX_JUMPS   = 2,
   parameter int FALL_STEP   = 5,
   parameter int ANIM_FRAMES = 6
) (
   input  logic                                CLK,
   input  logic                                RESET,
   input  logic                                frame_tick,
   input  logic                                run,
   input  logic                                restart,
   input  logic                                jump_req,
   input  logic                                duck,
   input  logic [8:0]                          row_addr,
   input  logic [9:0]                          col_addr,
   output logic [1+$clog2(SPR_W*SPR_H):0]      rom_addr,
   input  logic                                rom_data,
   output logic                                px,
   output logic                                airborne,
   output logic [9:0]                          height
);

   localparam int IDX_W = $clog2(SPR_W*SPR_H);
   localparam int TW    = $clog2(JUMP_T+1);
   localparam int JW    = $clog2(MAX_JUMPS+1);
   localparam int CW    = $clog2(ANIM_FRAMES+1);
   localparam int TOP0  = GROUND_Y - SPR_H;

   typedef enum logic [1:0] {GROUND, AIR, FALL} state_t;

   state_t          state, state_n;
   logic [TW-1:0]   t, t_n;
   logic [9:0]      base, base_n;
   logic [JW-1:0]   jumps, jumps_n;
   logic [CW-1:0]   anim_cnt, anim_n;
   logic            leg, leg_n;
   logic            jump_prev, jump_prev_n;
   logic            restart_pend, restart_pend_n;
   logic            press;
   logic [19:0]     arc_prod;
   logic [1:0]      frame_sel;
   int              row_off, col_off;
   logic            in_win;
   logic [IDX_W-1:0] index;
   logic            hit, hit_d;

   // Arc offset uses a 20-bit product so t*(JUMP_T-t) never overflows before the divide.
   always_comb begin
      arc_prod = 20'(t) * 20'(TW'(JUMP_T) - t);
      case (state)
         AIR:     height = 10'(20'(base) + arc_prod / 20'(HDIV));
         FALL:    height = base;
         default: height = '0;
      endcase
   end

   assign airborne = (state != GROUND);
   assign press    = jump_req & ~jump_prev;

   // NOTE: every variable gets a default at the top so no path can infer a latch.
   always_comb begin
      state_n        = state;
      t_n            = t;
      base_n         = base;
      jumps_n        = jumps;
      anim_n         = anim_cnt;
      leg_n          = leg;
      jump_prev_n    = jump_prev;
      restart_pend_n = restart_pend;
      if (frame_tick) begin
         jump_prev_n    = jump_req;
         restart_pend_n = 1'b0;
         if (restart || restart_pend) begin
            state_n = GROUND;
            t_n     = '0;
            base_n  = '0;
            jumps_n = '0;
            anim_n  = '0;
            leg_n   = 1'b0;
         end else if (run) begin
            case (state)
               GROUND: begin
                  if (press) begin
                     state_n = AIR;
                     t_n     = TW'(1);
                     base_n  = '0;
                     jumps_n = JW'(1);
                  end else if (anim_cnt == CW'(ANIM_FRAMES-1)) begin
                     anim_n = '0;
                     leg_n  = ~leg;
                  end else begin
                     anim_n = anim_cnt + CW'(1);
                  end
               end
               AIR: begin
                  if (press && (jumps < JW'(MAX_JUMPS))) begin
                     base_n  = height;
                     t_n     = TW'(1);
                     jumps_n = jumps + JW'(1);
                  end else if (t == TW'(JUMP_T)) begin
                     if (base == '0) begin
                        state_n = GROUND;
                        t_n     = '0;
                        jumps_n = '0;
                     end else begin
                        state_n = FALL;
                     end
                  end else begin
                     t_n = t + TW'(1);
                  end
               end
               FALL: begin
                  if (base <= 10'(FALL_STEP)) begin
                     base_n  = '0;
                     state_n = GROUND;
                     t_n     = '0;
                     jumps_n = '0;
                  end else begin
                     base_n = base - 10'(FALL_STEP);
                  end
               end
               default: state_n = GROUND;
            endcase
         end
      end else if (restart) begin
         restart_pend_n = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state        <= GROUND;
         t            <= '0;
         base         <= '0;
         jumps        <= '0;
         anim_cnt     <= '0;
         leg          <= 1'b0;
         jump_prev    <= 1'b0;
         restart_pend <= 1'b0;
      end else begin
         state        <= state_n;
         t            <= t_n;
         base         <= base_n;
         jumps        <= jumps_n;
         anim_cnt     <= anim_n;
         leg          <= leg_n;
         jump_prev    <= jump_prev_n;
         restart_pend <= restart_pend_n;
      end
   end

   always_comb begin
      if (state == GROUND && duck)     frame_sel = 2'd3;
      else if (state == GROUND && run) frame_sel = {1'b0, leg} + 2'd1;
      else                             frame_sel = 2'd0;
      row_off = int'(row_addr) - (TOP0 - int'(height));
      col_off = int'(col_addr) - X0;
      in_win  = (row_off >= 0) && (row_off < SPR_H) && (col_off >= 0) && (col_off < SPR_W);
      index   = IDX_W'(row_off * SPR_W + col_off);
   end

   // hit travels alongside the ROM's one-cycle read latency so px lines up with rom_data.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         rom_addr <= '0;
         hit      <= 1'b0;
         hit_d    <= 1'b0;
         px       <= 1'b0;
      end else begin
         hit   <= in_win;
         hit_d <= hit;
         px    <= hit_d & rom_data;
         if (in_win) rom_addr <= {frame_sel, index};
      end
   end

endmodule

// File: tb/tb_sprite_jump_engine.sv
// Self-checking bench for sprite_jump_engine: directed scenarios plus randomized ticks
// compared against a frame-level behavioural model and a synchronous ROM model.
module tb_sprite_jump_engine;

   localparam int SPR_W = 82, SPR_H = 88, X0 = 80, GROUND_Y = 402, JUMP_T = 60;
   localparam int HDIV = 6, MAX_JUMPS = 2, FALL_STEP = 5, ANIM_FRAMES = 6;
   localparam int M_GND = 0, M_AIR = 1, M_FALL = 2;

   logic        CLK = 1'b0, RESET = 1'b0;
   logic        frame_tick = 1'b0, run = 1'b0, restart = 1'b0, jump_req = 1'b0, duck = 1'b0;
   logic [8:0]  row_addr = '0;
   logic [9:0]  col_addr = '0;
   logic [14:0] rom_addr;
   logic        rom_data = 1'b0;
   logic        px, airborne;
   logic [9:0]  height;

   int n_checks = 0, n_fail = 0;
   int m_st, m_t, m_base, m_jumps, m_anim, m_leg, m_prev, m_rpend;
   int c_one;

   sprite_jump_engine dut (
      .CLK(CLK), .RESET(RESET), .frame_tick(frame_tick), .run(run), .restart(restart),
      .jump_req(jump_req), .duck(duck), .row_addr(row_addr), .col_addr(col_addr),
      .rom_addr(rom_addr), .rom_data(rom_data), .px(px), .airborne(airborne), .height(height)
   );

   always #5 CLK = ~CLK;

   function automatic logic rom_fn(input logic [14:0] a);
      return a[0] ^ a[2] ^ a[7] ^ a[13];
   endfunction

   always @(posedge CLK) rom_data <= rom_fn(rom_addr);

   // ---------------- behavioural model ----------------
   function automatic int m_height();
      if (m_st == M_AIR)  return m_base + (m_t * (JUMP_T - m_t)) / HDIV;
      if (m_st == M_FALL) return m_base;
      return 0;
   endfunction

   function automatic int m_fs();
      if (m_st == M_GND && duck) return 3;
      if (m_st == M_GND && run)  return 1 + m_leg;
      return 0;
   endfunction

   task automatic model_reset();
      m_st = M_GND; m_t = 0; m_base = 0; m_jumps = 0; m_anim = 0; m_leg = 0; m_prev = 0; m_rpend = 0;
   endtask

   task automatic model_tick();
      bit pr;
      pr = jump_req && !m_prev;
      m_prev = jump_req;
      if (restart || m_rpend) begin
         m_st = M_GND; m_t = 0; m_base = 0; m_jumps = 0; m_anim = 0; m_leg = 0;
      end else if (run) begin
         if (m_st == M_GND) begin
            if (pr) begin
               m_st = M_AIR; m_t = 1; m_base = 0; m_jumps = 1;
            end else begin
               m_anim++;
               if (m_anim == ANIM_FRAMES) begin m_anim = 0; m_leg = 1 - m_leg; end
            end
         end else if (m_st == M_AIR) begin
            if (pr && m_jumps < MAX_JUMPS) begin
               m_base = m_height(); m_t = 1; m_jumps++;
            end else if (m_t == JUMP_T) begin
               if (m_base == 0) begin m_st = M_GND; m_t = 0; m_jumps = 0; end
               else m_st = M_FALL;
            end else m_t++;
         end else begin
            m_base = m_base - FALL_STEP;
            if (m_base <= 0) begin m_base = 0; m_st = M_GND; m_t = 0; m_jumps = 0; end
         end
      end
      m_rpend = 0;
   endtask

   task automatic do_tick();
      @(negedge CLK); frame_tick = 1'b1;
      @(negedge CLK); frame_tick = 1'b0;
      model_tick();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      #2 RESET = 1'b1;
      #1;
      n_checks++;
      if ({px, airborne, height, rom_addr} !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got px=%b air=%b h=%0d addr=%0h expected all 0", px, airborne, height, rom_addr);
      end
      @(negedge CLK); @(negedge CLK);
      RESET = 1'b0;
      model_reset();
      @(negedge CLK);
      n_checks++;
      if (height !== 10'd0 || airborne !== 1'b0) begin
         n_fail++; $display("FAIL reset_release: got h=%0d air=%b expected 0 0", height, airborne);
      end
   endtask

   task automatic test_jump_arc();
      int cnt;
      run = 1'b1; jump_req = 1'b1; do_tick(); jump_req = 1'b0;
      n_checks++;
      if (airborne !== 1'b1 || height !== 10'(m_height())) begin
         n_fail++; $display("FAIL jump_start: got air=%b h=%0d expected 1 %0d", airborne, height, m_height());
      end
      for (int i = 0; i < 10; i++) do_tick();
      n_checks++;
      if (height !== 10'd89) begin n_fail++; $display("FAIL arc_t11: got %0d expected 89", height); end
      for (int i = 0; i < 19; i++) do_tick();
      n_checks++;
      if (height !== 10'd150) begin n_fail++; $display("FAIL arc_t30: got %0d expected 150", height); end
      cnt = 0;
      while (airborne === 1'b1 && cnt < 40) begin
         do_tick(); cnt++;
         n_checks++;
         if (height !== 10'(m_height())) begin
            n_fail++; $display("FAIL arc_descent: got %0d expected %0d", height, m_height());
         end
      end
      n_checks++;
      if (cnt != 31 || height !== 10'd0) begin
         n_fail++; $display("FAIL arc_land: got %0d ticks h=%0d expected 31 ticks h=0", cnt, height);
      end
   endtask

   task automatic test_double_jump();
      int cnt;
      jump_req = 1'b1; do_tick(); jump_req = 1'b0;
      for (int i = 0; i < 29; i++) do_tick();
      n_checks++;
      if (height !== 10'd150) begin n_fail++; $display("FAIL dj_first_peak: got %0d expected 150", height); end
      jump_req = 1'b1; do_tick(); jump_req = 1'b0;
      n_checks++;
      if (height !== 10'd159) begin n_fail++; $display("FAIL dj_second_start: got %0d expected 159", height); end
      for (int i = 0; i < 29; i++) do_tick();
      n_checks++;
      if (height !== 10'd300) begin n_fail++; $display("FAIL dj_second_peak: got %0d expected 300", height); end
      jump_req = 1'b1; do_tick(); jump_req = 1'b0;
      n_checks++;
      if (height !== 10'd299) begin n_fail++; $display("FAIL dj_third_ignored: got %0d expected 299", height); end
      cnt = 0;
      while (airborne === 1'b1 && cnt < 100) begin
         do_tick(); cnt++;
         n_checks++;
         if (height !== 10'(m_height()) || airborne !== (m_st != M_GND)) begin
            n_fail++; $display("FAIL dj_track: got h=%0d air=%b expected h=%0d air=%b", height, airborne, m_height(), m_st != M_GND);
         end
      end
      n_checks++;
      if (cnt != 60) begin n_fail++; $display("FAIL dj_land_ticks: got %0d expected 60", cnt); end
   endtask

   task automatic test_held_jump();
      int rises;
      logic prev_air;
      rises = 0; prev_air = airborne;
      jump_req = 1'b1;
      for (int i = 0; i < 100; i++) begin
         do_tick();
         if (airborne === 1'b1 && prev_air !== 1'b1) rises++;
         prev_air = airborne;
         n_checks++;
         if (height !== 10'(m_height())) begin
            n_fail++; $display("FAIL held_track: got %0d expected %0d", height, m_height());
         end
      end
      jump_req = 1'b0;
      n_checks++;
      if (rises != 1) begin n_fail++; $display("FAIL held_one_jump: got %0d jumps expected 1", rises); end
   endtask

   task automatic test_anim();
      logic [1:0] frozen;
      restart = 1'b1; do_tick(); restart = 1'b0;
      run = 1'b1; duck = 1'b0; row_addr = 9'd314; col_addr = 10'd80;
      for (int k = 1; k <= 14; k++) begin
         do_tick(); @(negedge CLK);
         n_checks++;
         if (rom_addr[14:13] !== 2'(1 + ((k / 6) % 2)) || rom_addr[12:0] !== 13'd0) begin
            n_fail++; $display("FAIL anim_tick%0d: got sel=%0d idx=%0d expected sel=%0d idx=0", k, rom_addr[14:13], rom_addr[12:0], 1 + ((k / 6) % 2));
         end
      end
      frozen = rom_addr[14:13];
      duck = 1'b1; @(negedge CLK); @(negedge CLK);
      n_checks++;
      if (rom_addr[14:13] !== 2'd3) begin n_fail++; $display("FAIL anim_duck: got %0d expected 3", rom_addr[14:13]); end
      duck = 1'b0; run = 1'b0;
      for (int i = 0; i < 8; i++) begin
         do_tick(); @(negedge CLK);
         n_checks++;
         if (rom_addr[14:13] !== 2'd0) begin n_fail++; $display("FAIL anim_stopped: got %0d expected 0", rom_addr[14:13]); end
      end
      run = 1'b1; @(negedge CLK); @(negedge CLK);
      n_checks++;
      if (rom_addr[14:13] !== frozen || rom_addr[14:13] !== 2'(m_fs())) begin
         n_fail++; $display("FAIL anim_frozen: got %0d expected %0d", rom_addr[14:13], frozen);
      end
   endtask

   task automatic test_pixel();
      logic [14:0] exp_addr;
      int r, c, ro, co;
      logic win;
      run = 1'b0; duck = 1'b0;
      c_one = -1;
      for (int k = 0; k < SPR_W; k++) begin
         exp_addr = 15'(k);
         if (c_one < 0 && rom_fn(exp_addr)) c_one = X0 + k;
      end
      row_addr = 9'd313; col_addr = 10'(c_one);
      repeat (3) @(negedge CLK);
      row_addr = 9'd314;
      exp_addr = 15'(c_one - X0);
      @(negedge CLK);
      n_checks++;
      if (rom_addr !== exp_addr || px !== 1'b0) begin
         n_fail++; $display("FAIL pix_lat1: got addr=%0h px=%b expected addr=%0h px=0", rom_addr, px, exp_addr);
      end
      @(negedge CLK);
      n_checks++;
      if (px !== 1'b0) begin n_fail++; $display("FAIL pix_lat2: got px=%b expected 0", px); end
      @(negedge CLK);
      n_checks++;
      if (px !== 1'b1) begin n_fail++; $display("FAIL pix_lat3: got px=%b expected 1", px); end
      col_addr = 10'd80; repeat (3) @(negedge CLK);
      exp_addr = 15'd0;
      n_checks++;
      if (rom_addr !== 15'd0 || px !== rom_fn(15'd0)) begin
         n_fail++; $display("FAIL pix_origin: got addr=%0h px=%b expected 0 %b", rom_addr, px, rom_fn(15'd0));
      end
      row_addr = 9'd313; repeat (3) @(negedge CLK);
      n_checks++;
      if (px !== 1'b0 || rom_addr !== exp_addr) begin
         n_fail++; $display("FAIL pix_row_above: got px=%b addr=%0h expected 0 %0h", px, rom_addr, exp_addr);
      end
      row_addr = 9'd314; col_addr = 10'd162; repeat (3) @(negedge CLK);
      n_checks++;
      if (px !== 1'b0 || rom_addr !== exp_addr) begin
         n_fail++; $display("FAIL pix_col_right: got px=%b addr=%0h expected 0 %0h", px, rom_addr, exp_addr);
      end
      for (int i = 0; i < 24; i++) begin
         r = $urandom_range(300, 410); c = $urandom_range(70, 170);
         row_addr = 9'(r); col_addr = 10'(c);
         ro = r - (GROUND_Y - SPR_H); co = c - X0;
         win = (ro >= 0 && ro < SPR_H && co >= 0 && co < SPR_W);
         if (win) exp_addr = 15'(ro * SPR_W + co);
         repeat (3) @(negedge CLK);
         n_checks++;
         if (rom_addr !== exp_addr || px !== (win & rom_fn(exp_addr))) begin
            n_fail++; $display("FAIL pix_rand r=%0d c=%0d: got addr=%0h px=%b expected %0h %b", r, c, rom_addr, px, exp_addr, win & rom_fn(exp_addr));
         end
      end
   endtask

   task automatic test_reset_mid_air();
      run = 1'b1; jump_req = 1'b1; do_tick(); jump_req = 1'b0;
      for (int i = 0; i < 19; i++) do_tick();
      n_checks++;
      if (height !== 10'd133) begin n_fail++; $display("FAIL mid_air_t20: got %0d expected 133", height); end
      row_addr = 9'(GROUND_Y - SPR_H - 133); col_addr = 10'(c_one);
      repeat (3) @(negedge CLK);
      n_checks++;
      if (px !== 1'b1) begin n_fail++; $display("FAIL mid_air_px: got %b expected 1", px); end
      #2 RESET = 1'b1;
      #1;
      n_checks++;
      if ({px, airborne, height, rom_addr} !== '0) begin
         n_fail++; $display("FAIL mid_air_reset: got px=%b air=%b h=%0d addr=%0h expected all 0", px, airborne, height, rom_addr);
      end
      @(negedge CLK); RESET = 1'b0; model_reset();
      row_addr = '0; col_addr = '0;
   endtask

   task automatic test_restart_fall();
      int cnt;
      jump_req = 1'b1; do_tick(); jump_req = 1'b0;
      for (int i = 0; i < 29; i++) do_tick();
      jump_req = 1'b1; do_tick(); jump_req = 1'b0;
      cnt = 0;
      while (m_st != M_FALL && cnt < 80) begin do_tick(); cnt++; end
      repeat (5) do_tick();
      n_checks++;
      if (airborne !== 1'b1 || height !== 10'(m_height()) || m_st != M_FALL) begin
         n_fail++; $display("FAIL fall_reached: got air=%b h=%0d expected 1 %0d", airborne, height, m_height());
      end
      @(negedge CLK); restart = 1'b1; @(negedge CLK); restart = 1'b0; m_rpend = 1;
      @(negedge CLK);
      n_checks++;
      if (height !== 10'(m_height()) || airborne !== 1'b1) begin
         n_fail++; $display("FAIL restart_pending: got h=%0d air=%b expected %0d 1", height, airborne, m_height());
      end
      jump_req = 1'b1; do_tick();
      n_checks++;
      if (height !== 10'd0 || airborne !== 1'b0) begin
         n_fail++; $display("FAIL restart_applied: got h=%0d air=%b expected 0 0", height, airborne);
      end
      do_tick(); jump_req = 1'b0;
      n_checks++;
      if (airborne !== 1'b0) begin n_fail++; $display("FAIL restart_press_consumed: got air=%b expected 0", airborne); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         run      = ($urandom_range(0, 9) != 0);
         jump_req = ($urandom_range(0, 3) == 0);
         duck     = ($urandom_range(0, 3) == 0);
         restart  = ($urandom_range(0, 49) == 0);
         do_tick();
         restart = 1'b0;
         if ($urandom_range(0, 39) == 0) begin
            @(negedge CLK); restart = 1'b1; @(negedge CLK); restart = 1'b0; m_rpend = 1;
         end
         n_checks++;
         if (height !== 10'(m_height()) || airborne !== (m_st != M_GND)) begin
            n_fail++; $display("FAIL rand_tick%0d: got h=%0d air=%b expected h=%0d air=%b", i, height, airborne, m_height(), m_st != M_GND);
         end
         if (i % 8 == 0) begin
            row_addr = 9'(GROUND_Y - SPR_H - m_height()); col_addr = 10'(X0);
            @(negedge CLK); @(negedge CLK);
            n_checks++;
            if (rom_addr !== {2'(m_fs()), 13'd0}) begin
               n_fail++; $display("FAIL rand_sel%0d: got %0h expected %0h", i, rom_addr, {2'(m_fs()), 13'd0});
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_jump_arc();
      test_double_jump();
      test_held_jump();
      test_anim();
      test_pixel();
      test_reset_mid_air();
      test_restart_fall();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached before the summary");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sprite_jump_engine.md
# sprite_jump_engine

Parametrised successor to the single-sprite jump renderer in the dinosaur game. Owns the player's vertical motion (parabolic jump, optional multi-jump, linear fall-back), selects one of four sprite frames (stand/air, run A, run B, duck) and produces the player pixel for the VGA scan-out. Sprite bitmaps live in an external synchronous ROM, so the module carries no pattern storage. All logic runs on the single pixel clock, with a frame strobe as the frame-rate enable.

## Interface
- SPR_W, 82: sprite width, pixels
- SPR_H, 88: sprite height, pixels
- X0, 80: left column of sprite
- GROUND_Y, 402: row just below sprite when height = 0
- JUMP_T, 60: frames per parabolic arc
- HDIV, 6: arc divisor
- MAX_JUMPS, 2: jumps allowed before landing (1 = no multi-jump)
- FALL_STEP, 5: pixels per frame in FALL
- ANIM_FRAMES, 6: frames per run-leg toggle
- Legality: GROUND_Y - SPR_H - MAX_JUMPS*(JUMP_T²/4/HDIV) >= 0
- CLK  in  1  pixel clock
- RESET  in  1  reset, asynchronous, active-high
- frame_tick  in  1  one-CLK pulse per frame, sync to CLK
- run  in  1  game running; 0 freezes motion and animation
- restart  in  1  sync; returns to ground, any state
- jump_req  in  1  jump button level
- duck  in  1  duck button level
- row_addr  in  9  scan row
- col_addr  in  10  scan column
- rom_addr  out  2+clog2(SPR_W*SPR_H)  {frame_sel, row*SPR_W+col}, registered
- rom_data  in  1  ROM bit, valid one CLK after rom_addr
- px  out  1  player pixel, registered
- airborne  out  1  state != GROUND
- height  out  10  current vertical offset, pixels

## Operation
- States: GROUND, AIR, FALL. Registers: t (0..JUMP_T), base (10 b), jumps, anim_cnt, leg, jump_prev.
- height: GROUND 0; AIR base + (t*(JUMP_T-t))/HDIV (integer, truncating, ≥20-bit intermediate); FALL base.
- Press = jump_req & ~jump_prev, evaluated only on tick; jump_prev updates every tick regardless of run.
- Per tick, priority order: restart → GROUND, t=0, base=0, jumps=0, anim_cnt=0, leg=0 (even if run=0). Else if run=0, hold all except jump_prev. Else:
- GROUND: press → AIR, t=1, base=0, jumps=1. Else anim_cnt++; at ANIM_FRAMES-1 wrap to 0 and toggle leg.
- AIR: press & jumps<MAX_JUMPS → base=current height, t=1, jumps++. Else t==JUMP_T → GROUND (t=0, jumps=0) if base==0, otherwise FALL. Else t++.
- FALL: base = max(base-FALL_STEP, 0); when the result is 0, go to GROUND with t=0 and jumps=0. Presses are ignored.
- restart without a tick is latched and applied on the next tick.
- frame_sel: 3 if GROUND & duck; 1+leg if GROUND & ~duck & run; else 0.
- Window: row in [GROUND_Y-SPR_H-height, GROUND_Y-height) and col in [X0, X0+SPR_W). Index = (row-top)*SPR_W + (col-X0), col 0 is leftmost. Outside the window px=0 and rom_addr holds its last value.

## Timing
- Reset values: state GROUND, all counters 0, jump_prev 0, px 0, rom_addr 0, hit pipe 0, airborne 0, height 0.
- State and height change on the CLK edge where frame_tick=1; height/airborne are combinational from these registers.
- Pixel pipe: row/col sampled at edge E → rom_addr and hit registered at E → rom_data valid after E+1 → px = hit_d & rom_data registered at E+2. Latency is 2 CLK; the scan-out compensates.
- Height is stable between ticks, so a frame never tears mid-line.
- Simultaneous restart+press: restart wins. Simultaneous tick with run=0 and press: the press is consumed (jump_prev updates) and no jump occurs.

## Test plan
- Reset, then run=1, press on tick 1 → AIR; after 10 more ticks (t=11) height=(11*49)/6=89; at t=30 height=150; after tick 60 → GROUND, height 0.
- Double jump: press at t=30 (height 150) → base=150, t=1; at new t=30 height=300; at t=60 → FALL; 30 ticks later GROUND; a third press in AIR is ignored.
- Held jump_req across 100 ticks → exactly one jump (edge detect).
- GROUND, run=1, duck=0 → frame_sel toggles 1/2 every 6 ticks; duck=1 → rom_addr high bits = 3; run=0 → frame_sel 0 and counters frozen.
- Pixel: height 0, drive row 314 col 80 → rom_addr index 0, px = rom_data two CLK later; row 313 or col 162 → px 0.
- Assert RESET mid-AIR (t=20) → all outputs 0 immediately; restart pulse mid-FALL → GROUND on next tick.
